// File: rtl/vc_pkg.sv
// Shared constants and types for the weighted round-robin virtual-channel arbiter.
// Channel indices, the inactive-weight code and the arbiter state encoding live here.
package vc_pkg;

    localparam int NUM_CH   = 4;
    localparam int W_WIDTH  = 4;
    localparam int IDX_W    = $clog2(NUM_CH);

    localparam logic [W_WIDTH-1:0] INACTIVE = 4'h0;

    localparam logic [IDX_W-1:0] VCHANEL0 = 2'b00;
    localparam logic [IDX_W-1:0] VCHANEL1 = 2'b01;
    localparam logic [IDX_W-1:0] VCHANEL2 = 2'b10;
    localparam logic [IDX_W-1:0] VCHANEL3 = 2'b11;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    function automatic logic [NUM_CH-1:0] onehot(input logic [IDX_W-1:0] idx);
        return {{(NUM_CH-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/rr_next_sel.sv
// Combinational cyclic search: first channel with a nonzero weight,
// scanning from start upward with wrap-around.
module rr_next_sel
    import vc_pkg::*;
(
    input  logic [NUM_CH-1:0][W_WIDTH-1:0] weights,
    input  logic [IDX_W-1:0]               start,
    output logic                           found,
    output logic [IDX_W-1:0]               sel,
    output logic [W_WIDTH-1:0]             sel_weight
);

    always_comb begin
        // NOTE: every output gets a default before the loop so no latch is inferred.
        found      = 1'b0;
        sel        = start;
        sel_weight = INACTIVE;
        // Scan farthest offset first so the nearest active channel wins last.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            logic [IDX_W-1:0] idx;
            idx = start + i[IDX_W-1:0];
            if (weights[idx] != INACTIVE) begin
                found      = 1'b1;
                sel        = idx;
                sel_weight = weights[idx];
            end
        end
    end

endmodule

// File: rtl/weighted_rr_arbiter.sv
// Weighted round-robin arbiter over four virtual channels: each channel keeps the
// grant for as many consecutive enabled cycles as its weight, sampled at turn start.
module weighted_rr_arbiter #(
    parameter int NUM_CH  = vc_pkg::NUM_CH,
    parameter int W_WIDTH = vc_pkg::W_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enb,
    input  logic [W_WIDTH-1:0] vchanel0,
    input  logic [W_WIDTH-1:0] vchanel1,
    input  logic [W_WIDTH-1:0] vchanel2,
    input  logic [W_WIDTH-1:0] vchanel3,
    output logic [NUM_CH-1:0]  demux,
    output logic [1:0]         arbiter
);

    import vc_pkg::IDX_W;
    import vc_pkg::VCHANEL0;
    import vc_pkg::arb_state_t;
    import vc_pkg::IDLE;
    import vc_pkg::GRANT;
    import vc_pkg::onehot;

    arb_state_t                        state;
    logic [IDX_W-1:0]                  ptr;
    logic [W_WIDTH-1:0]                cred;

    logic [NUM_CH-1:0][W_WIDTH-1:0]    weights;
    logic [IDX_W-1:0]                  start;
    logic                              found;
    logic [IDX_W-1:0]                  sel;
    logic [W_WIDTH-1:0]                sel_weight;

    assign weights = {vchanel3, vchanel2, vchanel1, vchanel0};

    // A fresh turn in IDLE may re-pick ptr itself; after a finished turn ptr goes last.
    assign start = (state == GRANT) ? ptr + 1'b1 : ptr;

    rr_next_sel u_next_sel (
        .weights    (weights),
        .start      (start),
        .found      (found),
        .sel        (sel),
        .sel_weight (sel_weight)
    );

    // NOTE: state and outputs use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= VCHANEL0;
            cred    <= '0;
            arbiter <= VCHANEL0;
            demux   <= '0;
        end else if (!enb) begin
            demux   <= '0;
        end else if (state == GRANT && cred != '0) begin
            cred    <= cred - 1'b1;
            arbiter <= ptr;
            demux   <= onehot(ptr);
        end else if (found) begin
            state   <= GRANT;
            ptr     <= sel;
            cred    <= sel_weight - 1'b1;
            arbiter <= sel;
            demux   <= onehot(sel);
        end else begin
            state   <= IDLE;
            demux   <= '0;
        end
    end

endmodule

// File: tb/tb_weighted_rr_arbiter.sv
// Self-checking bench for weighted_rr_arbiter: expected grants come from hand-derived
// turn sequences, queued per cycle and compared after each rising edge.
module tb_weighted_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       enb;
    logic [3:0] vchanel0, vchanel1, vchanel2, vchanel3;
    logic [3:0] demux;
    logic [1:0] arbiter;

    typedef struct {
        string      tag;
        logic [3:0] demux;
        logic [1:0] arbiter;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    weighted_rr_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .enb      (enb),
        .vchanel0 (vchanel0),
        .vchanel1 (vchanel1),
        .vchanel2 (vchanel2),
        .vchanel3 (vchanel3),
        .demux    (demux),
        .arbiter  (arbiter)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // One clock: queue the expectation, let the edge happen, compare just after it.
    task automatic cycle(input string tag, input logic [3:0] e_demux, input logic [1:0] e_arb);
        exp_t e;
        exp_q.push_back('{tag, e_demux, e_arb});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check({e.tag, ".demux"}, 8'(demux), 8'(e.demux));
        check({e.tag, ".arbiter"}, 8'(arbiter), 8'(e.arbiter));
    endtask

    task automatic grant(input string tag, input logic [1:0] ch, input int n);
        for (int i = 0; i < n; i++) cycle(tag, 4'b0001 << ch, ch);
    endtask

    task automatic idle(input string tag, input logic [1:0] arb, input int n);
        for (int i = 0; i < n; i++) cycle(tag, 4'b0000, arb);
    endtask

    task automatic set_w(input logic [3:0] w0, w1, w2, w3);
        vchanel0 = w0; vchanel1 = w1; vchanel2 = w2; vchanel3 = w3;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        cycle(tag, 4'b0000, 2'b00);
        rst = 1'b0;
    endtask

    initial begin
        int seq1234 [10] = '{0, 1, 1, 2, 2, 2, 3, 3, 3, 3};
        int seq2001 [3]  = '{0, 0, 3};

        rst = 1'b1;
        enb = 1'b0;
        set_w(4'd0, 4'd0, 4'd0, 4'd0);
        @(posedge clk);
        #1;
        do_reset("reset");

        // Weights 1,2,3,4: period-10 pattern with no bubbles between turns.
        set_w(4'd1, 4'd2, 4'd3, 4'd4);
        enb = 1'b1;
        for (int i = 0; i < 20; i++) grant("w1234", 2'(seq1234[i % 10]), 1);

        // All inactive: nothing granted; then a lone channel is granted continuously.
        do_reset("reset_w0");
        set_w(4'd0, 4'd0, 4'd0, 4'd0);
        idle("all_inactive", 2'b00, 20);
        vchanel2 = 4'd5;
        grant("lone_ch2", 2'd2, 12);

        // Inactive channels in the middle are skipped.
        do_reset("reset_w2001");
        set_w(4'd2, 4'd0, 4'd0, 4'd1);
        for (int i = 0; i < 9; i++) grant("w2001", 2'(seq2001[i % 3]), 1);

        // enb gap mid-turn: demux drops, arbiter holds, remaining credit resumes.
        do_reset("reset_gap");
        set_w(4'd3, 4'd3, 4'd3, 4'd3);
        grant("gap_ch0", 2'd0, 3);
        grant("gap_ch1_pre", 2'd1, 1);
        enb = 1'b0;
        idle("gap_off", 2'd1, 4);
        enb = 1'b1;
        grant("gap_ch1_post", 2'd1, 2);
        grant("gap_ch2", 2'd2, 3);
        grant("gap_ch3", 2'd3, 1);

        // Reset during channel 2's turn restarts at channel 0.
        do_reset("reset_mid_pre");
        set_w(4'd1, 4'd1, 4'd4, 4'd1);
        grant("mid_ch0", 2'd0, 1);
        grant("mid_ch1", 2'd1, 1);
        grant("mid_ch2", 2'd2, 1);
        do_reset("reset_mid");
        grant("restart_ch0", 2'd0, 1);
        grant("restart_ch1", 2'd1, 1);
        grant("restart_ch2", 2'd2, 4);
        grant("restart_ch3", 2'd3, 1);
        grant("restart_wrap", 2'd0, 1);

        // Weight change mid-turn only affects the next turn.
        do_reset("reset_wchg");
        set_w(4'd1, 4'd4, 4'd1, 4'd1);
        grant("wchg_ch0", 2'd0, 1);
        grant("wchg_ch1_a", 2'd1, 1);
        vchanel1 = 4'd1;
        grant("wchg_ch1_b", 2'd1, 3);
        grant("wchg_ch2", 2'd2, 1);
        grant("wchg_ch3", 2'd3, 1);
        grant("wchg_ch0b", 2'd0, 1);
        grant("wchg_ch1_next", 2'd1, 1);
        grant("wchg_ch2b", 2'd2, 1);

        // Weight dropped to 0 before its turn is skipped; maximum weight gives 15 cycles.
        do_reset("reset_max");
        set_w(4'd15, 4'd1, 4'd2, 4'd0);
        grant("max_ch0", 2'd0, 1);
        vchanel1 = 4'd0;
        grant("max_ch0_rest", 2'd0, 14);
        grant("skip_to_ch2", 2'd2, 2);
        grant("max_wrap", 2'd0, 15);

        check("queue_drained", 8'(exp_q.size()), 8'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/weighted_rr_arbiter.md
# weighted_rr_arbiter

Weighted round-robin arbiter over four virtual channels. Each channel has a 4-bit weight, and the arbiter grants it that many consecutive cycles before moving to the next channel with nonzero weight. It sits between the virtual-channel FIFOs and the output demultiplexer. It drives a one-hot demux select and a 2-bit index of the channel currently served.

## Interface
Parameters:
- NUM_CH, 4: number of virtual channels (fixed at 4; not user-varied).
- W_WIDTH, 4: weight width in bits.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- enb  input  1  enable; 0 freezes arbitration.
- vchanel0  input  4  weight of channel 0; 4'h0 = INACTIVE.
- vchanel1  input  4  weight of channel 1.
- vchanel2  input  4  weight of channel 2.
- vchanel3  input  4  weight of channel 3.
- demux  output  4  one-hot grant; bit N = channel N served; 4'b0000 = no grant.
- arbiter  output  2  index of the channel currently or last served (VCHANEL0..3 = 2'b00..2'b11).

## Operation
- State: 2-bit pointer `ptr`, 4-bit credit counter `cred`, state flag IDLE/GRANT.
- Reset (rst=1 at an edge):
  - ptr=0, cred=0, state=IDLE.
  - arbiter=2'b00, demux=4'b0000.
  - rst has priority over enb.
- enb=0:
  - ptr, cred and state hold.
  - arbiter holds.
  - demux=4'b0000.
- enb=1, IDLE:
  - Search channels cyclically starting at ptr (ptr included) for the first nonzero weight.
  - If found: ptr=that channel, cred=weight-1, state=GRANT.
  - If none (all INACTIVE): stay IDLE, demux=0000, arbiter holds.
- enb=1, GRANT:
  - If cred>0: cred decrements; ptr holds.
  - If cred==0: search cyclically starting at ptr+1 (wrapping through ptr itself last) for the first nonzero weight.
    - If found: load ptr and cred=weight-1.
    - If none: go to IDLE with demux=0000.
- A channel with the only nonzero weight is re-granted continuously.
- Weights are sampled only when a channel's turn starts.
  - Changing the current channel's weight mid-turn has no effect until its next turn.
  - A weight that drops to 0 before its turn causes the channel to be skipped.
- Outputs in GRANT with enb=1: arbiter=ptr, demux=1<<ptr.
- Credit arithmetic is unsigned 4-bit with no overflow: maximum weight 15 gives 15 cycles.

## Timing
- All outputs are registered.
- First grant appears on the first rising edge at which enb=1 and rst=0 with a nonzero weight present. Outputs are valid just after that edge (1-cycle latency from sampled inputs).
- A channel of weight w holds demux for exactly w consecutive enabled cycles. The next channel's grant starts on the following edge, with no idle bubble between turns.
- enb deassertion takes effect at the next edge (demux=0000). Reasserting enb resumes with the remaining credit.
- Reset mid-turn: the next edge gives arbiter=00 and demux=0000, and arbitration restarts from channel 0.

## Structure
- Shared package `vc_pkg`:
  - INACTIVE = 4'h0.
  - VCHANEL0..VCHANEL3 = 2'b00..2'b11.
  - NUM_CH, W_WIDTH.
- Sub-module `rr_next_sel`: combinational cyclic search.
  - Inputs: 4 weights, start index.
  - Outputs: found flag, selected index, selected weight.
  - Instantiated once; the start index is muxed between ptr (IDLE) and ptr+1 (GRANT).
- Top level holds the ptr/cred/state registers and the output decode.

## Test plan
- Weights 1,2,3,4 with enb=1 after reset: arbiter sequence 0,1,1,2,2,2,3,3,3,3 repeating with period 10. demux tracks it: 0001,0010,0010,0100,...
- Weights 0,0,0,0 with enb=1: demux=0000 and arbiter=00 for 20 cycles. Then set vchanel2=5: arbiter=10 and demux=0100 on every cycle from the next edge.
- Weights 2,0,0,1: arbiter pattern 0,0,3 repeating; channels 1 and 2 are never granted.
- Weights 3,3,3,3: drop enb for 4 cycles mid-turn of channel 1 after its first cycle. demux=0000 during the gap; resume with exactly 2 more cycles of channel 1, then channel 2.
- Assert rst for 1 cycle during channel 2's turn (weights 1,1,4,1): arbiter=00 and demux=0000 at the next edge. The following enabled edge grants channel 0.
- Change vchanel1 from 4 to 1 during channel 1's turn: the current turn still lasts 4 cycles and the next channel-1 turn lasts 1 cycle.
